// File: rtl/ctrl_mdio_sched_if.sv
// Bus bundle between the CPU register path, the MDIO scheduler and the MDIO frame engine.
// master = CPU decode plus MDIO engine side; slave = the scheduler.
interface ctrl_mdio_sched_if;
    logic        cpu_req;
    logic        cpu_wr;
    logic [4:0]  cpu_phy_addr;
    logic [4:0]  cpu_reg_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic        cpu_err;

    logic        mdio_req;
    logic        mdio_wr;
    logic [4:0]  mdio_phy_addr;
    logic [4:0]  mdio_reg_addr;
    logic [15:0] mdio_wdata;
    logic        mdio_done;
    logic [15:0] mdio_rdata;

    modport master (
        output cpu_req, cpu_wr, cpu_phy_addr, cpu_reg_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata, cpu_err,
        input  mdio_req, mdio_wr, mdio_phy_addr, mdio_reg_addr, mdio_wdata,
        output mdio_done, mdio_rdata
    );

    modport slave (
        input  cpu_req, cpu_wr, cpu_phy_addr, cpu_reg_addr, cpu_wdata,
        output cpu_ack, cpu_rdata, cpu_err,
        output mdio_req, mdio_wr, mdio_phy_addr, mdio_reg_addr, mdio_wdata,
        input  mdio_done, mdio_rdata
    );
endinterface

// File: rtl/ctrl_mdio_sched.sv
// Shares one MDIO engine between the CPU register path and a periodic PHY status poller,
// and derives link/speed state from the polled register in hardware.
module ctrl_mdio_sched #(
    parameter logic [31:0] POLL_INTERVAL = 32'd10_000_000,
    parameter logic [4:0]  POLL_REG      = 5'd17,
    parameter int          LINK_BIT      = 10,
    parameter logic [15:0] TIMEOUT       = 16'd4096
) (
    input  logic              sys_clk,
    input  logic              rst,
    ctrl_mdio_sched_if.slave  bus,
    input  logic              poll_en,
    input  logic [4:0]        poll_phy_addr,
    output logic              phy_link_up,
    output logic              phy_giga_mode,
    output logic              link_change,
    output logic [7:0]        poll_timeouts
);

    typedef enum logic [1:0] {IDLE, XFER, FINISH} state_t;
    typedef enum logic {OWN_CPU, OWN_POLL} owner_t;

    state_t      state_reg, state_next;
    owner_t      owner_reg;

    logic [31:0] timer_reg;
    logic        poll_pending_reg;
    logic        last_poll_reg;

    logic        mdio_req_reg;
    logic        mdio_wr_reg;
    logic [4:0]  mdio_phy_reg;
    logic [4:0]  mdio_reg_addr_reg;
    logic [15:0] mdio_wdata_reg;
    logic [15:0] tout_cnt_reg;

    logic        cpu_ack_reg;
    logic [15:0] cpu_rdata_reg;
    logic        cpu_err_reg;
    logic        link_up_reg;
    logic        giga_reg;
    logic        chg_reg;
    logic        link_change_reg;
    logic [7:0]  poll_timeouts_reg;

    logic        grant_cpu, grant_poll;
    logic        xfer_end, timed_out;
    logic        timer_wrap;
    logic        new_link, new_giga;

    assign timer_wrap = (timer_reg == POLL_INTERVAL - 32'd1);
    assign new_link   = bus.mdio_rdata[LINK_BIT];
    assign new_giga   = (bus.mdio_rdata[15:14] == 2'b10) && new_link;

    // Arbitration and transaction sequencing. On a tie the requester not served last wins.
    always_comb begin
        state_next = state_reg;
        grant_cpu  = 1'b0;
        grant_poll = 1'b0;
        xfer_end   = 1'b0;
        timed_out  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.cpu_req && (!poll_pending_reg || last_poll_reg)) begin
                    grant_cpu = 1'b1;
                end else if (poll_pending_reg) begin
                    grant_poll = 1'b1;
                end
                if (grant_cpu || grant_poll) begin
                    state_next = XFER;
                end
            end
            XFER: begin
                if (bus.mdio_done) begin
                    xfer_end   = 1'b1;
                    state_next = FINISH;
                end else if (tout_cnt_reg == TIMEOUT - 16'd1) begin
                    xfer_end   = 1'b1;
                    timed_out  = 1'b1;
                    state_next = FINISH;
                end
            end
            FINISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A wrap always re-arms the poll, even if it lands on the grant cycle of the previous one.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            timer_reg        <= 32'd0;
            poll_pending_reg <= 1'b0;
        end else if (!poll_en) begin
            timer_reg        <= 32'd0;
            poll_pending_reg <= 1'b0;
        end else begin
            timer_reg <= timer_wrap ? 32'd0 : timer_reg + 32'd1;
            if (timer_wrap) begin
                poll_pending_reg <= 1'b1;
            end else if (grant_poll) begin
                poll_pending_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_reg         <= IDLE;
            owner_reg         <= OWN_CPU;
            last_poll_reg     <= 1'b1;
            mdio_req_reg      <= 1'b0;
            mdio_wr_reg       <= 1'b0;
            mdio_phy_reg      <= 5'd0;
            mdio_reg_addr_reg <= 5'd0;
            mdio_wdata_reg    <= 16'd0;
            tout_cnt_reg      <= 16'd0;
            cpu_ack_reg       <= 1'b0;
            cpu_rdata_reg     <= 16'd0;
            cpu_err_reg       <= 1'b0;
            link_up_reg       <= 1'b0;
            giga_reg          <= 1'b0;
            chg_reg           <= 1'b0;
            link_change_reg   <= 1'b0;
            poll_timeouts_reg <= 8'd0;
        end else begin
            state_reg       <= state_next;
            cpu_ack_reg     <= 1'b0;
            chg_reg         <= 1'b0;
            link_change_reg <= chg_reg;

            if (grant_cpu || grant_poll) begin
                owner_reg         <= grant_poll ? OWN_POLL : OWN_CPU;
                last_poll_reg     <= grant_poll;
                mdio_req_reg      <= 1'b1;
                mdio_wr_reg       <= grant_poll ? 1'b0 : bus.cpu_wr;
                mdio_phy_reg      <= grant_poll ? poll_phy_addr : bus.cpu_phy_addr;
                mdio_reg_addr_reg <= grant_poll ? POLL_REG : bus.cpu_reg_addr;
                mdio_wdata_reg    <= grant_poll ? 16'd0 : bus.cpu_wdata;
                tout_cnt_reg      <= 16'd0;
            end

            // Results land on the edge into FINISH so they are visible during the FINISH cycle.
            if (state_reg == XFER) begin
                tout_cnt_reg <= tout_cnt_reg + 16'd1;
                if (xfer_end) begin
                    mdio_req_reg <= 1'b0;
                    if (owner_reg == OWN_CPU) begin
                        cpu_ack_reg   <= 1'b1;
                        cpu_rdata_reg <= timed_out ? 16'hFFFF : bus.mdio_rdata;
                        cpu_err_reg   <= timed_out;
                    end else if (timed_out) begin
                        if (poll_timeouts_reg != 8'hFF) begin
                            poll_timeouts_reg <= poll_timeouts_reg + 8'd1;
                        end
                    end else begin
                        link_up_reg <= new_link;
                        giga_reg    <= new_giga;
                        chg_reg     <= (new_link != link_up_reg) || (new_giga != giga_reg);
                    end
                end
            end
        end
    end

    assign bus.mdio_req      = mdio_req_reg;
    assign bus.mdio_wr       = mdio_wr_reg;
    assign bus.mdio_phy_addr = mdio_phy_reg;
    assign bus.mdio_reg_addr = mdio_reg_addr_reg;
    assign bus.mdio_wdata    = mdio_wdata_reg;
    assign bus.cpu_ack       = cpu_ack_reg;
    assign bus.cpu_rdata     = cpu_rdata_reg;
    assign bus.cpu_err       = cpu_err_reg;
    assign phy_link_up       = link_up_reg;
    assign phy_giga_mode     = giga_reg;
    assign link_change       = link_change_reg;
    assign poll_timeouts     = poll_timeouts_reg;

endmodule

// File: tb/tb_ctrl_mdio_sched.sv
// Scoreboard bench for ctrl_mdio_sched: the bench plays CPU and MDIO engine, and a monitor
// checks every completed transaction against expectations queued when it was issued.
module tb_ctrl_mdio_sched;
    localparam int       TO       = 64;
    localparam logic [4:0] POLL_PHY = 5'd31;

    logic       sys_clk = 1'b0;
    logic       rst;
    logic       poll_en;
    logic [4:0] poll_phy_addr;
    logic       phy_link_up, phy_giga_mode, link_change;
    logic [7:0] poll_timeouts;
    int         cyc = 0;

    ctrl_mdio_sched_if bus();

    ctrl_mdio_sched #(.POLL_INTERVAL(32'd100), .POLL_REG(5'd17), .LINK_BIT(10), .TIMEOUT(16'd64)) dut (
        .sys_clk(sys_clk), .rst(rst), .bus(bus),
        .poll_en(poll_en), .poll_phy_addr(poll_phy_addr),
        .phy_link_up(phy_link_up), .phy_giga_mode(phy_giga_mode),
        .link_change(link_change), .poll_timeouts(poll_timeouts)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        logic wr; logic [4:0] phy; logic [4:0] regad; logic [15:0] wdata; logic [15:0] data; int lat;
    } cpu_plan_t;
    typedef struct {
        logic is_cpu; int len; logic [15:0] rdata; logic err;
        logic link; logic giga; logic chg; logic [7:0] touts;
    } exp_t;

    cpu_plan_t cpu_plan_q[$];
    exp_t      exp_q[$];
    int        owner_log[$];
    int        n_cmp = 0, n_bad = 0;
    int        n_polls = 0;
    int        poll_mode = 2;
    logic      m_link = 1'b0, m_giga = 1'b0;
    int        m_touts = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    function automatic int pick_lat();
        int r;
        r = int'($urandom_range(9));
        if (r == 0) return TO;
        if (r == 1) return 1;
        if (r == 2) return 1000;
        return int'($urandom_range(60, 2));
    endfunction

    function automatic logic [15:0] pick_status();
        case ($urandom_range(7))
            0: return 16'h8400;
            1: return 16'h0400;
            2: return 16'h0000;
            3: return 16'hC400;
            4: return 16'h4400;
            5: return 16'h8000;
            6: return 16'h8401;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [63:0] out_vec();
        return {7'd0, bus.mdio_req, bus.mdio_wr, bus.mdio_phy_addr, bus.mdio_reg_addr, bus.mdio_wdata,
                bus.cpu_ack, bus.cpu_rdata, bus.cpu_err, phy_link_up, phy_giga_mode, link_change, poll_timeouts};
    endfunction

    // Engine model: entered on the first negedge that shows mdio_req high.
    task automatic serve();
        logic        wr0; logic [4:0] phy0, reg0; logic [15:0] wd0, d;
        logic        nl, ng;
        int          lat, k, unstable;
        exp_t        e;
        cpu_plan_t   p;
        wr0 = bus.mdio_wr; phy0 = bus.mdio_phy_addr; reg0 = bus.mdio_reg_addr; wd0 = bus.mdio_wdata;
        e = '{is_cpu: 1'b0, len: 0, rdata: 16'h0, err: 1'b0, link: 1'b0, giga: 1'b0, chg: 1'b0, touts: 8'h0};
        if (phy0 == POLL_PHY) begin
            check("poll_fields", {wr0, reg0, wd0}, {1'b0, 5'd17, 16'h0000});
            case (poll_mode)
                1: begin lat = 1000; d = 16'h0000; end
                2: begin lat = 10;   d = 16'h8400; end
                default: begin lat = pick_lat(); d = pick_status(); end
            endcase
            if (lat > TO) begin
                e.len = TO;
                if (m_touts < 255) m_touts++;
            end else begin
                e.len = lat;
                nl = d[10];
                ng = (d[15:14] == 2'b10) && nl;
                e.chg = (nl != m_link) || (ng != m_giga);
                m_link = nl;
                m_giga = ng;
            end
            e.link = m_link; e.giga = m_giga; e.touts = 8'(m_touts);
            n_polls++;
            owner_log.push_back(1);
        end else begin
            if (cpu_plan_q.size() == 0) begin
                bound_fail("cpu_plan_missing");
                lat = 1; d = 16'h0;
            end else begin
                p = cpu_plan_q.pop_front();
                check("cpu_fields", {wr0, phy0, reg0, wd0}, {p.wr, p.phy, p.regad, p.wdata});
                lat = p.lat; d = p.data;
            end
            e.is_cpu = 1'b1;
            e.len    = (lat > TO) ? TO : lat;
            e.rdata  = (lat > TO) ? 16'hFFFF : d;
            e.err    = (lat > TO);
            owner_log.push_back(0);
        end
        exp_q.push_back(e);
        k = 1; unstable = 0;
        forever begin
            if (rst || !bus.mdio_req || k > 200) break;
            if ({bus.mdio_wr, bus.mdio_phy_addr, bus.mdio_reg_addr, bus.mdio_wdata} != {wr0, phy0, reg0, wd0})
                unstable++;
            if (k == lat) begin
                bus.mdio_done  = 1'b1;
                bus.mdio_rdata = d;
                @(negedge sys_clk);
                bus.mdio_done  = 1'b0;
                bus.mdio_rdata = 16'($urandom);
                break;
            end
            @(negedge sys_clk);
            k++;
        end
        if (!rst) check("mdio_stable", 64'(unstable), 64'd0);
    endtask

    initial begin
        bus.mdio_done  = 1'b0;
        bus.mdio_rdata = 16'h0;
        forever begin
            @(negedge sys_clk);
            bus.mdio_done = 1'b0;
            if (rst) continue;
            if (bus.mdio_req) begin
                serve();
            end else if ($urandom_range(7) == 0) begin
                // stray completion pulses outside a transfer must be ignored
                bus.mdio_done  = 1'b1;
                bus.mdio_rdata = 16'($urandom);
            end
        end
    end

    // Monitor: a transaction is presented on the cycle mdio_req falls (the FINISH cycle).
    initial begin
        int   run;
        logic lc_due, lc_exp;
        exp_t e;
        run = 0; lc_due = 1'b0; lc_exp = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (rst) begin run = 0; lc_due = 1'b0; continue; end
            if (lc_due) check("link_change", 64'(link_change), 64'(lc_exp));
            else if (link_change) check("link_change_spurious", 64'(link_change), 64'd0);
            lc_due = 1'b0;
            if (bus.mdio_req) begin
                run++;
            end else if (run > 0) begin
                if (exp_q.size() == 0) begin
                    bound_fail("exp_q_empty");
                end else begin
                    e = exp_q.pop_front();
                    check("req_len", 64'(run), 64'(e.len));
                    if (e.is_cpu) begin
                        check("cpu_ack", 64'(bus.cpu_ack), 64'd1);
                        check("cpu_rdata", 64'(bus.cpu_rdata), 64'(e.rdata));
                        check("cpu_err", 64'(bus.cpu_err), 64'(e.err));
                    end else begin
                        check("cpu_ack_on_poll", 64'(bus.cpu_ack), 64'd0);
                        check("link_state", {62'd0, phy_link_up, phy_giga_mode}, {62'd0, e.link, e.giga});
                        check("poll_timeouts", 64'(poll_timeouts), 64'(e.touts));
                        lc_due = 1'b1;
                        lc_exp = e.chg;
                    end
                end
                run = 0;
            end else if (bus.cpu_ack) begin
                check("cpu_ack_spurious", 64'(bus.cpu_ack), 64'd0);
            end
        end
    end

    task automatic cpu_xact(input logic wr, input logic [4:0] phy, input logic [4:0] regad,
                            input logic [15:0] wdata, input logic [15:0] data, input int lat);
        int i;
        cpu_plan_q.push_back('{wr: wr, phy: phy, regad: regad, wdata: wdata, data: data, lat: lat});
        bus.cpu_wr = wr; bus.cpu_phy_addr = phy; bus.cpu_reg_addr = regad; bus.cpu_wdata = wdata;
        bus.cpu_req = 1'b1;
        i = 0;
        forever begin
            @(negedge sys_clk);
            if (bus.cpu_ack) break;
            if (++i > 3000) begin bound_fail("cpu_ack_wait"); break; end
        end
        bus.cpu_req = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic wait_idle(input string what);
        int i;
        repeat (3) @(negedge sys_clk);
        i = 0;
        while ((exp_q.size() != 0 || bus.mdio_req) && i < 5000) begin
            @(negedge sys_clk);
            i++;
        end
        if (i >= 5000) bound_fail(what);
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic wait_owners(input int n, input string what);
        int i;
        i = 0;
        while (owner_log.size() < n && i < 2000) begin @(negedge sys_clk); i++; end
        if (i >= 2000) bound_fail(what);
    endtask

    initial begin
        int c, idx, base, i;
        rst = 1'b1; poll_en = 1'b0; poll_phy_addr = POLL_PHY;
        bus.cpu_req = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_phy_addr = 5'd0;
        bus.cpu_reg_addr = 5'd0; bus.cpu_wdata = 16'd0;
        repeat (3) @(negedge sys_clk);
        check("reset_outputs", out_vec(), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge sys_clk);

        // CPU read with a 50-cycle engine
        cpu_xact(1'b0, 5'd1, 5'd2, 16'h0000, 16'h0141, 50);

        // two identical polls: first reports a change, second does not
        poll_mode = 2;
        poll_en = 1'b1;
        wait_owners(owner_log.size() + 2, "two_polls");
        poll_en = 1'b0;
        wait_idle("idle_after_polls");

        // ties between cpu_req and poll_pending
        cpu_xact(1'b1, 5'd4, 5'd9, 16'hBEEF, 16'h1234, 5);
        poll_en = 1'b1;
        c = cyc;
        while (cyc != c + 100) @(negedge sys_clk);
        idx = owner_log.size();
        cpu_xact(1'b0, 5'd2, 5'd3, 16'h0, 16'h5A5A, 8);
        wait_owners(idx + 2, "tie1_owners");
        if (owner_log.size() >= idx + 2) begin
            check("tie_after_cpu_first", 64'(owner_log[idx]), 64'd1);
            check("tie_after_cpu_second", 64'(owner_log[idx + 1]), 64'd0);
        end
        while (cyc != c + 300) @(negedge sys_clk);
        idx = owner_log.size();
        cpu_xact(1'b0, 5'd6, 5'd7, 16'h0, 16'hA5A5, 8);
        wait_owners(idx + 2, "tie2_owners");
        if (owner_log.size() >= idx + 2) begin
            check("tie_after_poll_first", 64'(owner_log[idx]), 64'd0);
            check("tie_after_poll_second", 64'(owner_log[idx + 1]), 64'd1);
        end
        poll_en = 1'b0;
        wait_idle("idle_after_ties");

        // CPU timeout, then boundary: done exactly on the last allowed cycle
        cpu_xact(1'b0, 5'd3, 5'd1, 16'h0, 16'h7777, 1000);
        cpu_xact(1'b0, 5'd3, 5'd1, 16'h0, 16'h6666, TO);

        // randomized mix with polling active
        poll_mode = 0;
        poll_en = 1'b1;
        for (int n = 0; n < 40; n++) begin
            cpu_xact(1'($urandom), 5'($urandom_range(30)), 5'($urandom), 16'($urandom),
                     16'($urandom), pick_lat());
            repeat ($urandom_range(8)) @(negedge sys_clk);
        end

        // every poll times out until the counter saturates
        poll_mode = 1;
        base = n_polls;
        i = 0;
        while (n_polls < base + 258 && i < 40000) begin @(negedge sys_clk); i++; end
        if (i >= 40000) bound_fail("saturation_polls");
        poll_en = 1'b0;
        wait_idle("idle_after_saturation");

        // asynchronous reset in the middle of a transfer
        cpu_plan_q.push_back('{wr: 1'b0, phy: 5'd3, regad: 5'd4, wdata: 16'h0, data: 16'h0, lat: 1000});
        bus.cpu_wr = 1'b0; bus.cpu_phy_addr = 5'd3; bus.cpu_reg_addr = 5'd4; bus.cpu_wdata = 16'h0;
        bus.cpu_req = 1'b1;
        i = 0;
        while (!bus.mdio_req && i < 100) begin @(negedge sys_clk); i++; end
        if (i >= 100) bound_fail("mdio_req_before_reset");
        repeat (20) @(posedge sys_clk);
        #2 rst = 1'b1;
        #1 check("reset_mid_xfer", out_vec(), 64'd0);
        bus.cpu_req = 1'b0;
        repeat (3) @(negedge sys_clk);
        cpu_plan_q.delete();
        exp_q.delete();
        m_link = 1'b0; m_giga = 1'b0; m_touts = 0;
        rst = 1'b0;
        repeat (2) @(negedge sys_clk);
        cpu_xact(1'b0, 5'd8, 5'd2, 16'h0, 16'hC0DE, 12);
        wait_idle("idle_at_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d mismatched=%0d", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
